dcp_wrr_dispatcher: RTL
=======================

# dcp_wrr_dispatcher

Single-input, multi-output weighted round-robin dispatcher on the Decoupled valid/ready interface. It is the fan-out counterpart of the read-control WRR arbiter. It deals incoming beats to `ARB_NUM` output streams in a fixed, weight-proportional order, so a downstream arbiter loaded with the same weights restores the original beat order. Each output has a one-entry registered buffer.

## Interface
- `DW`, 8, payload width in bits
- `ARB_NUM`, 8, number of output streams
- `WEIGHT_NUM`, 8, maximum weight; weight field is `$clog2(WEIGHT_NUM)+1` bits

- `iClk`  in  1  clock; single clock domain
- `iRst_n`  in  1  reset; asynchronous, active-low
- `iDcpIn`  Decoupled.slave  `DW`  input stream: `Vld`, `Pld`, `Rdy` (driven by this block)
- `oDcpOut[0:ARB_NUM-1]`  Decoupled.master  `DW` each  output streams
- `iWeight[ARB_NUM]`  in  `$clog2(WEIGHT_NUM)+1` each  per-output weight
- `iWeightLoad`  in  1  one-cycle strobe that captures `iWeight`

## Operation
- **State registers:**
  - `wReg[i]`: weight, reset value 1.
  - `cnt[i]`: beats dealt to output i in the current turn, reset value 0.
  - `ptr`: current target output, reset value 0.
  - `bufVld[i]` / `bufPld[i]`: per-output buffer, reset values 0.
- **Output drive:** `oDcpOut[i].Vld = bufVld[i]`; `oDcpOut[i].Pld = bufPld[i]`.
- **Accept condition:** `iDcpIn.Rdy = !iWeightLoad && wReg[ptr]!=0 && (!bufVld[ptr] || oDcpOut[ptr].Rdy)`. An input beat is accepted when `iDcpIn.Vld && iDcpIn.Rdy`.
- **On accept:**
  - `bufPld[ptr] <= iDcpIn.Pld` and `bufVld[ptr] <= 1`.
  - If `cnt[ptr]+1 == wReg[ptr]`: `cnt[ptr] <= 0` and `ptr` advances to the next index with nonzero weight, searching upward with wrap from `ARB_NUM-1` to 0. Otherwise `cnt[ptr]` increments.
- **Buffer drain:** `bufVld[i]` clears when `oDcpOut[i].Rdy` is high and output i is not receiving a new beat in the same cycle. Simultaneous drain and refill of the same buffer keeps `Vld` at 1 and carries the new payload.
- **No skipping:** a full, stalled target output blocks the input. The dispatcher never jumps ahead to a free output, because strict order is required for downstream reassembly.
- **Weight load** (`iWeightLoad` = 1):
  - `wReg[i] <= min(iWeight[i], WEIGHT_NUM)`.
  - All `cnt <= 0`.
  - `ptr <=` lowest index with nonzero new weight, or 0 if all new weights are zero.
  - Input is not accepted in the load cycle. Buffered beats are unaffected and keep draining.
- **All weights zero:** `iDcpIn.Rdy` stays 0 until the next load with a nonzero weight.
- **Arithmetic:** `cnt` is `$clog2(WEIGHT_NUM)+1` bits. It never exceeds `wReg-1`, so it cannot wrap.

## Timing
- **Latency:** one cycle from input accept to `oDcpOut[ptr].Vld`.
- **Throughput:** one beat per cycle when the target output's `Rdy` is high or its buffer is empty.
- **Combinational paths:**
  - `iDcpIn.Rdy` depends on `oDcpOut[ptr].Rdy` (same-cycle drain-through) and on `iWeightLoad`.
  - There is no combinational path from `iDcpIn.Vld` to any output.
- **Handshake rules:** output `Vld`/`Pld` hold stable until accepted. `Rdy` is never used to gate `Vld`.
- **Reset:** asserting `iRst_n` low at any time (including mid-stream) immediately clears every `bufVld`, `cnt` and `ptr` and drops buffered beats. `oDcpOut[*].Vld` = 0 while reset is asserted. `iDcpIn.Rdy` = 1 on the first cycle after release, since default weights are 1 and buffers are empty.

## Test plan
- **Default weights, all outputs ready:** send 16 beats with payloads 0x00–0x0F → output i receives i, then i+8, each exactly one cycle after accept; no stall cycles.
- **Weighted order:** load weights {3,1,0,0,0,0,0,2}, send 12 beats 0x00–0x0B → output 0 gets 00,01,02; output 1 gets 03; output 7 gets 04,05; output 0 gets 06,07,08; output 1 gets 09; output 7 gets 0A,0B. Outputs 2–6 never assert `Vld`.
- **Backpressure without skipping:** default weights, output 0 `Rdy` = 0, send 9 beats → beats 0–7 accepted; beat 8 stalls with `iDcpIn.Rdy` = 0. Raising output 0 `Rdy` delivers 0x00 and accepts 0x08 in the same cycle, and `Vld` stays 1.
- **Weight load edge cases:**
  - Load all zeros → `iDcpIn.Rdy` = 0 indefinitely.
  - Then load {0,0,15,...} with `WEIGHT_NUM`=8 → `ptr`=2 and weight clamped to 8; output 2 receives 8 consecutive beats.
- **Load mid-stream:** `iDcpIn.Vld` held high, `iWeightLoad` pulsed → `Rdy` = 0 in the load cycle, counters restart, and the next beat goes to the lowest nonzero-weight output.
- **Asynchronous reset mid-operation:** with outputs 0–3 holding stalled beats, assert `iRst_n` low between clock edges → all `oDcpOut[*].Vld` drop to 0 without waiting for a clock edge. After release, the first beat goes to output 0.

Source files
------------

// File: rtl/dcp_wrr_dispatcher.sv
// Weighted round-robin fan-out: deals input beats to ARB_NUM outputs in a fixed
// weight-proportional order, each output backed by a one-entry registered buffer.
module dcp_wrr_dispatcher #(
  parameter int unsigned DW         = 8,
  parameter int unsigned ARB_NUM    = 8,
  parameter int unsigned WEIGHT_NUM = 8
) (
  input  logic                             iClk,
  input  logic                             iRst_n,
  input  logic                             iDcpInVld,
  input  logic [DW-1:0]                    iDcpInPld,
  output logic                             oDcpInRdy,
  output logic [ARB_NUM-1:0]               oDcpOutVld,
  output logic [ARB_NUM-1:0][DW-1:0]       oDcpOutPld,
  input  logic [ARB_NUM-1:0]               iDcpOutRdy,
  input  logic [ARB_NUM-1:0][$clog2(WEIGHT_NUM):0] iWeight,
  input  logic                             iWeightLoad
);

  localparam int unsigned WW = $clog2(WEIGHT_NUM) + 1;
  localparam int unsigned PW = (ARB_NUM > 1) ? $clog2(ARB_NUM) : 1;

  logic [ARB_NUM-1:0][WW-1:0] w_q,   w_d;
  logic [ARB_NUM-1:0][WW-1:0] cnt_q, cnt_d;
  logic [PW-1:0]              ptr_q, ptr_d;
  logic [ARB_NUM-1:0]         buf_vld_q, buf_vld_d;
  logic [ARB_NUM-1:0][DW-1:0] buf_pld_q, buf_pld_d;

  logic [ARB_NUM-1:0][WW-1:0] w_clamp;
  logic [PW-1:0]              load_ptr;
  logic [PW-1:0]              nxt_ptr;
  logic [PW-1:0]              cand;
  logic                       found;
  logic                       rdy;
  logic                       accept;

  // Clamp incoming weights and find the lowest output that will own the first turn.
  always_comb begin
    w_clamp  = '0;
    load_ptr = '0;
    for (int i = int'(ARB_NUM) - 1; i >= 0; i--) begin
      w_clamp[i] = (iWeight[i] > WW'(WEIGHT_NUM)) ? WW'(WEIGHT_NUM) : iWeight[i];
      if (w_clamp[i] != '0) load_ptr = PW'(i);
    end
  end

  // Next output with nonzero weight above ptr, wrapping; lands on ptr itself if it is the only one.
  always_comb begin
    nxt_ptr = ptr_q;
    found   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= int'(ARB_NUM); k++) begin
      cand = PW'((int'(ptr_q) + k) % int'(ARB_NUM));
      if (!found && (w_q[cand] != '0)) begin
        nxt_ptr = cand;
        found   = 1'b1;
      end
    end
  end

  assign rdy    = !iWeightLoad && (w_q[ptr_q] != '0) &&
                  (!buf_vld_q[ptr_q] || iDcpOutRdy[ptr_q]);
  assign accept = iDcpInVld && rdy;

  always_comb begin
    w_d       = w_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    buf_vld_d = buf_vld_q;
    buf_pld_d = buf_pld_q;

    for (int i = 0; i < int'(ARB_NUM); i++) begin
      if (iDcpOutRdy[i]) buf_vld_d[i] = 1'b0;
    end

    // A refill overrides the drain of the same buffer so Vld stays high.
    if (accept) begin
      buf_vld_d[ptr_q] = 1'b1;
      buf_pld_d[ptr_q] = iDcpInPld;
      if ((cnt_q[ptr_q] + WW'(1)) == w_q[ptr_q]) begin
        cnt_d[ptr_q] = '0;
        ptr_d        = nxt_ptr;
      end else begin
        cnt_d[ptr_q] = cnt_q[ptr_q] + WW'(1);
      end
    end

    if (iWeightLoad) begin
      w_d   = w_clamp;
      cnt_d = '0;
      ptr_d = load_ptr;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int i = 0; i < int'(ARB_NUM); i++) w_q[i] <= WW'(1);
      cnt_q     <= '0;
      ptr_q     <= '0;
      buf_vld_q <= '0;
      buf_pld_q <= '0;
    end else begin
      w_q       <= w_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      buf_vld_q <= buf_vld_d;
      buf_pld_q <= buf_pld_d;
    end
  end

  assign oDcpInRdy  = rdy;
  assign oDcpOutVld = buf_vld_q;
  assign oDcpOutPld = buf_pld_q;

endmodule
